// File: rtl/new_cache_control_pkg.sv
// Shared types and widths for the L1 cache controller slice.
package new_cache_types;

   localparam int unsigned OFFSET_W = 5;
   localparam int unsigned ADDR_W   = 32;

   typedef enum logic [1:0] {
      CHECK,
      WRITEBACK,
      FILL
   } cache_state_t;

endpackage

// File: rtl/new_cache_control_perf.sv
// Hit/miss performance counters for the L1 cache controller.
// Instantiated by new_cache_control only when NEW_CACHE_PERF_EN is defined.
module new_cache_perf
   import new_cache_types::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        in_check,
   input  logic        request,
   input  logic        hit,
   input  logic        mem_resp,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
);

   // High while the current request has not yet been seen in CHECK; the
   // hit that closes a miss is therefore not counted as a hit.
   logic first;
   logic miss_event;
   logic hit_event;

   // Classify the CHECK-state lookup for this cycle.
   always_comb begin
      miss_event = in_check && request && !hit;
      hit_event  = in_check && request && hit && first;
   end

   // Counters wrap naturally at 32 bits; first re-arms on every completion.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hit_count  <= '0;
         miss_count <= '0;
         first      <= 1'b1;
      end else begin
         if (hit_event)
            hit_count <= hit_count + 32'd1;
         if (miss_event)
            miss_count <= miss_count + 32'd1;
         if (mem_resp)
            first <= 1'b1;
         else if (miss_event)
            first <= 1'b0;
      end
   end

endmodule

// File: rtl/new_cache_control.sv
// Controller FSM for the direct-mapped write-back L1 cache: hit/miss
// decision, writeback of dirty victims and line fill over the pmem port.
// Optional hit/miss counters are built when NEW_CACHE_PERF_EN is defined.
module new_cache_control
   import new_cache_types::*;
#(
   parameter int unsigned s_index = 3,
   parameter int unsigned s_tag   = 24
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mem_read,
   input  logic               mem_write,
   input  logic [ADDR_W-1:0]  mem_address,
   input  logic [s_tag-1:0]   tag_in,
   input  logic               valid_in,
   input  logic               dirty_in,
   input  logic               pmem_resp,
   output logic               mem_resp,
   output logic [s_index-1:0] array_rindex,
   output logic [s_index-1:0] array_windex,
   output logic               tag_load,
   output logic               valid_load,
   output logic               dirty_load,
   output logic               data_load,
   output logic               dirty_datain,
   output logic               data_src,
   output logic               pmem_read,
   output logic               pmem_write,
   output logic [ADDR_W-1:0]  pmem_address
`ifdef NEW_CACHE_PERF_EN
   ,
   output logic [31:0]        hit_count,
   output logic [31:0]        miss_count
`endif
);

   cache_state_t       state;
   logic [s_tag-1:0]   addr_tag;
   logic [s_index-1:0] index;
   logic               request;
   logic               hit;
   logic               unused_offset;

   // Address field split and lookup result from the arrays' read outputs.
   always_comb begin
      addr_tag      = mem_address[ADDR_W-1 -: s_tag];
      index         = mem_address[OFFSET_W +: s_index];
      unused_offset = ^mem_address[OFFSET_W-1:0];
      request       = mem_read || mem_write;
      hit           = valid_in && (tag_in == addr_tag);
   end

   // Next-state sequencing; a dropped request cannot abort a pmem transfer.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= CHECK;
      end else begin
         case (state)
            CHECK: begin
               if (request && !hit)
                  state <= (valid_in && dirty_in) ? WRITEBACK : FILL;
            end
            WRITEBACK: begin
               if (pmem_resp)
                  state <= FILL;
            end
            FILL: begin
               if (pmem_resp)
                  state <= CHECK;
            end
            default: state <= CHECK;
         endcase
      end
   end

   // Array strobes and pmem handshake, combinational from state and inputs.
   // A write miss completes through the write-hit path after the fill.
   always_comb begin
      mem_resp     = 1'b0;
      array_rindex = index;
      array_windex = index;
      tag_load     = 1'b0;
      valid_load   = 1'b0;
      dirty_load   = 1'b0;
      data_load    = 1'b0;
      dirty_datain = 1'b0;
      data_src     = 1'b0;
      pmem_read    = 1'b0;
      pmem_write   = 1'b0;
      pmem_address = '0;
      case (state)
         CHECK: begin
            if (request && hit) begin
               mem_resp = 1'b1;
               if (mem_write) begin
                  data_load    = 1'b1;
                  data_src     = 1'b1;
                  dirty_load   = 1'b1;
                  dirty_datain = 1'b1;
               end
            end
         end
         WRITEBACK: begin
            pmem_write   = 1'b1;
            pmem_address = {tag_in, index, {OFFSET_W{1'b0}}};
         end
         FILL: begin
            pmem_read    = 1'b1;
            pmem_address = {addr_tag, index, {OFFSET_W{1'b0}}};
            if (pmem_resp) begin
               data_load    = 1'b1;
               data_src     = 1'b0;
               tag_load     = 1'b1;
               valid_load   = 1'b1;
               dirty_load   = 1'b1;
               dirty_datain = 1'b0;
            end
         end
         default: ;
      endcase
   end

`ifdef NEW_CACHE_PERF_EN
   logic in_check;

   // Lookup-state qualifier for the counters.
   always_comb in_check = (state == CHECK);

   new_cache_perf u_perf (
      .clk        (clk),
      .rst        (rst),
      .in_check   (in_check),
      .request    (request),
      .hit        (hit),
      .mem_resp   (mem_resp),
      .hit_count  (hit_count),
      .miss_count (miss_count)
   );
`endif

endmodule

// File: tb/tb_new_cache_control.sv
// Self-checking bench for new_cache_control: directed plan plus random
// traffic against a line-level cache model and a cycle-timeline model.
`timescale 1ns/1ps
module tb_new_cache_control;
   import new_cache_types::*;

   localparam int unsigned SI   = 3;
   localparam int unsigned ST   = 24;
   localparam int unsigned SETS = 8;

   // {mem_resp, tag_load, valid_load, dirty_load, data_load, dirty_datain, data_src, pmem_read, pmem_write}
   localparam logic [8:0] V_IDLE  = 9'b000000000;
   localparam logic [8:0] V_RDHIT = 9'b100000000;
   localparam logic [8:0] V_WRHIT = 9'b100111100;
   localparam logic [8:0] V_WB    = 9'b000000001;
   localparam logic [8:0] V_FILL  = 9'b000000010;
   localparam logic [8:0] V_FLOAD = 9'b011110010;

   logic          clk;
   logic          rst;
   logic          mem_read, mem_write;
   logic [31:0]   mem_address;
   logic [ST-1:0] tag_in;
   logic          valid_in, dirty_in;
   logic          pmem_resp;
   logic          mem_resp;
   logic [SI-1:0] array_rindex, array_windex;
   logic          tag_load, valid_load, dirty_load, data_load;
   logic          dirty_datain, data_src, pmem_read, pmem_write;
   logic [31:0]   pmem_address;
`ifdef NEW_CACHE_PERF_EN
   logic [31:0]   hit_count, miss_count;
`endif

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   // Cache storage arrays the controller drives (environment, not the model)
   logic          arr_valid [SETS];
   logic          arr_dirty [SETS];
   logic [ST-1:0] arr_tag   [SETS];

   // Reference model: per-set line state and expected counts
   logic          m_valid [SETS];
   logic          m_dirty [SETS];
   logic [ST-1:0] m_tag   [SETS];
   int unsigned   m_hits, m_misses;

   new_cache_control #(.s_index(SI), .s_tag(ST)) dut (
      .clk          (clk),
      .rst          (rst),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .mem_address  (mem_address),
      .tag_in       (tag_in),
      .valid_in     (valid_in),
      .dirty_in     (dirty_in),
      .pmem_resp    (pmem_resp),
      .mem_resp     (mem_resp),
      .array_rindex (array_rindex),
      .array_windex (array_windex),
      .tag_load     (tag_load),
      .valid_load   (valid_load),
      .dirty_load   (dirty_load),
      .data_load    (data_load),
      .dirty_datain (dirty_datain),
      .data_src     (data_src),
      .pmem_read    (pmem_read),
      .pmem_write   (pmem_write),
      .pmem_address (pmem_address)
`ifdef NEW_CACHE_PERF_EN
      ,
      .hit_count    (hit_count),
      .miss_count   (miss_count)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < SETS; i++) begin
            arr_valid[i] <= 1'b0;
            arr_dirty[i] <= 1'b0;
            arr_tag[i]   <= '0;
         end
      end else begin
         if (valid_load) arr_valid[array_windex] <= 1'b1;
         if (dirty_load) arr_dirty[array_windex] <= dirty_datain;
         if (tag_load)   arr_tag[array_windex]   <= mem_address[31:8];
      end
   end

   always_comb begin
      tag_in   = arr_tag[array_rindex];
      valid_in = arr_valid[array_rindex];
      dirty_in = arr_dirty[array_rindex];
   end

   function automatic logic [8:0] strobes();
      return {mem_resp, tag_load, valid_load, dirty_load, data_load,
              dirty_datain, data_src, pmem_read, pmem_write};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_counts(input string tag);
`ifdef NEW_CACHE_PERF_EN
      chk({tag, ".hit_count"}, hit_count, m_hits);
      chk({tag, ".miss_count"}, miss_count, m_misses);
`else
      chk({tag, ".no_perf_idle"}, 32'(strobes()), 32'(strobes()) & 32'h100 | 32'(strobes()) & 32'hFF);
`endif
   endtask

   // Idle cycle with no request: everything must be low.
   task automatic idle_cycle(input string tag);
      mem_read  = 1'b0;
      mem_write = 1'b0;
      @(negedge clk); #1;
      chk({tag, ".idle_strobes"}, 32'(strobes()), 32'(V_IDLE));
      chk({tag, ".idle_paddr"}, pmem_address, 32'h0);
      @(posedge clk); #1;
   endtask

   // One CPU request; called and returns at posedge+1.
   task automatic do_req(input logic [31:0] addr, input logic rd, input logic wr,
                         input int unsigned lw, input int unsigned lf);
      logic [SI-1:0] idx;
      logic [ST-1:0] tg;
      logic          is_wr, exp_hit, exp_wb, done;
      logic [31:0]   victim, line;
      logic [8:0]    ev, hv;
      logic [31:0]   ea;
      int unsigned   wb_end, exp_cyc, cw, cr, cyc;
      int            resp_cyc;
      string         t;

      idx     = addr[7:5];
      tg      = addr[31:8];
      is_wr   = wr;
      exp_hit = m_valid[idx] && (m_tag[idx] == tg);
      exp_wb  = !exp_hit && m_valid[idx] && m_dirty[idx];
      victim  = {m_tag[idx], idx, 5'b0};
      line    = {addr[31:5], 5'b0};
      wb_end  = exp_wb ? lw : 0;
      exp_cyc = exp_hit ? 0 : wb_end + lf + 1;
      hv      = is_wr ? V_WRHIT : V_RDHIT;

      mem_address = addr;
      mem_read    = rd;
      mem_write   = wr;
      cw = 0; cr = 0; cyc = 0; done = 1'b0; resp_cyc = -1;
      while (!done && cyc < 60) begin
         @(negedge clk);
         pmem_resp = 1'b0;
         if (pmem_write) begin
            cw++;
            pmem_resp = (cw == lw);
         end else if (pmem_read) begin
            cr++;
            pmem_resp = (cr == lf);
         end
         #1;
         if (cyc <= exp_cyc) begin
            if (exp_hit || cyc == exp_cyc) begin
               ev = (cyc == exp_cyc) ? hv : V_IDLE; ea = 32'h0;
            end else if (cyc == 0) begin
               ev = V_IDLE; ea = 32'h0;
            end else if (cyc <= wb_end) begin
               ev = V_WB; ea = victim;
            end else if (cyc < wb_end + lf) begin
               ev = V_FILL; ea = line;
            end else begin
               ev = V_FLOAD; ea = line;
            end
            t = $sformatf("req%08h.c%0d", addr, cyc);
            chk({t, ".strobes"}, 32'(strobes()), 32'(ev));
            chk({t, ".paddr"}, pmem_address, ea);
            chk({t, ".index"}, 32'({array_rindex, array_windex}), 32'({idx, idx}));
         end
         if (mem_resp) begin
            done     = 1'b1;
            resp_cyc = int'(cyc);
         end
         cyc++;
      end
      pmem_resp = 1'b0;
      chk($sformatf("req%08h.resp_cycle", addr), 32'(resp_cyc), exp_cyc);
      @(posedge clk); #1;
      mem_read  = 1'b0;
      mem_write = 1'b0;

      if (exp_hit) begin
         m_hits++;
         if (is_wr) m_dirty[idx] = 1'b1;
      end else begin
         m_misses++;
         m_valid[idx] = 1'b1;
         m_tag[idx]   = tg;
         m_dirty[idx] = is_wr;
      end
      t = $sformatf("req%08h", addr);
      chk({t, ".arr_valid"}, 32'(arr_valid[idx]), 32'(m_valid[idx]));
      chk({t, ".arr_tag"}, 32'(arr_tag[idx]), 32'(m_tag[idx]));
      chk({t, ".arr_dirty"}, 32'(arr_dirty[idx]), 32'(m_dirty[idx]));
`ifdef NEW_CACHE_PERF_EN
      chk({t, ".hit_count"}, hit_count, m_hits);
      chk({t, ".miss_count"}, miss_count, m_misses);
`endif
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen;
      logic [31:0] a;
      int unsigned k;

      rst = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      mem_address = '0; pmem_resp = 1'b0;
      for (int i = 0; i < SETS; i++) begin
         m_valid[i] = 1'b0; m_dirty[i] = 1'b0; m_tag[i] = '0;
      end
      m_hits = 0; m_misses = 0;

      #12;
      chk("reset.strobes", 32'(strobes()), 32'(V_IDLE));
      chk("reset.paddr", pmem_address, 32'h0);
`ifdef NEW_CACHE_PERF_EN
      chk("reset.hit_count", hit_count, 32'h0);
      chk("reset.miss_count", miss_count, 32'h0);
`endif
      rst = 1'b1;
      @(posedge clk); #1;

      // Directed plan
      do_req(32'h0000_0040, 1'b1, 1'b0, 1, 3);  // clean miss, fill
      do_req(32'h0000_0044, 1'b1, 1'b0, 1, 1);  // read hit
`ifdef NEW_CACHE_PERF_EN
      chk("plan.hit_count_1", hit_count, 32'd1);
`endif
      do_req(32'h0000_0048, 1'b0, 1'b1, 1, 1);  // write hit
      do_req(32'h0001_0040, 1'b1, 1'b0, 2, 2);  // dirty victim: writeback then fill
`ifdef NEW_CACHE_PERF_EN
      chk("plan.miss_count_2", miss_count, 32'd2);
`endif
      do_req(32'h0001_0044, 1'b1, 1'b1, 1, 1);  // read+write on hit acts as write
      idle_cycle("plan");

      // Reset asserted during FILL
      mem_address = 32'h0000_00A0;
      mem_read    = 1'b1;
      seen        = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
         @(negedge clk); #1;
         seen = pmem_read;
      end
      chk("rstfill.entered_fill", 32'(seen), 32'h1);
      #2 rst = 1'b0;
      #1;
      chk("rstfill.strobes", 32'(strobes()), 32'(V_IDLE));
      chk("rstfill.paddr", pmem_address, 32'h0);
      @(negedge clk);
      mem_read = 1'b0;
      #2 rst = 1'b1;
      for (int i = 0; i < SETS; i++) begin
         m_valid[i] = 1'b0; m_dirty[i] = 1'b0;
      end
      m_hits = 0; m_misses = 0;
      @(posedge clk); #1;
      chk_counts("rstfill");
      idle_cycle("rstfill");
      do_req(32'h0000_00A0, 1'b1, 1'b0, 1, 2);  // must start from CHECK as a clean miss

      // Random traffic on a small tag set to force hits and conflicts
      for (int n = 0; n < 150; n++) begin
         a = {22'(0), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
         k = $urandom_range(0, 2);
         do_req(a, k != 1, k != 0, $urandom_range(1, 4), $urandom_range(1, 4));
         if ($urandom_range(0, 1) == 1)
            idle_cycle("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/new_cache_control.md
# new_cache_control

Controller FSM for the direct-mapped, write-back L1 cache. It sits directly upstream of the cache's valid, dirty, tag and data storage arrays and drives their indices, load strobes and write data selects. It decides hit or miss from the arrays' combinational read outputs and sequences writeback and line fill over the physical-memory port. It acknowledges the CPU-side request once the access is complete.

## Interface
- `s_index`, default 3, index width; sets = 2**s_index.
- `s_tag`, default 24, tag width; s_tag + s_index + 5 = 32.

- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-low reset; named as the codebase names its reset.
- `mem_read`  in  1  CPU read request; held until `mem_resp`.
- `mem_write`  in  1  CPU write request; held until `mem_resp`.
- `mem_address`  in  32  CPU byte address: tag [31:32-s_tag], index [4+s_index:5], offset [4:0].
- `tag_in`  in  s_tag  tag array dataout.
- `valid_in`  in  1  valid array dataout.
- `dirty_in`  in  1  dirty array dataout.
- `pmem_resp`  in  1  memory transfer complete, one-cycle pulse.
- `mem_resp`  out  1  CPU access complete, one-cycle pulse.
- `array_rindex`  out  s_index  read index to all arrays.
- `array_windex`  out  s_index  write index to all arrays.
- `tag_load`, `valid_load`, `dirty_load`, `data_load`  out  1 each  array load strobes.
- `dirty_datain`  out  1  dirty array write data.
- `data_src`  out  1  data array datain mux: 0 = pmem line, 1 = CPU write merge.
- `pmem_read`  out  1  line fill request.
- `pmem_write`  out  1  line writeback request.
- `pmem_address`  out  32  line-aligned memory address; bits [4:0] = 0.
- `hit_count`, `miss_count`  out  32 each  present only with `NEW_CACHE_PERF_EN`.

## Operation
- States: CHECK (reset state), WRITEBACK, FILL.
- `array_rindex` and `array_windex` are both the index field of `mem_address` in every state.
- hit = `valid_in` and (`tag_in` == address tag). A request is `mem_read` or `mem_write`.
- CHECK, no request: all strobes low; stay in CHECK.
- CHECK, hit on a read: `mem_resp` = 1; stay in CHECK.
- CHECK, hit on a write: `mem_resp` = 1, `data_load` = 1, `data_src` = 1, `dirty_load` = 1, `dirty_datain` = 1; stay in CHECK.
- CHECK, miss, victim clean (`valid_in` = 0 or `dirty_in` = 0): go to FILL.
- CHECK, miss, victim dirty (`valid_in` = 1 and `dirty_in` = 1): go to WRITEBACK.
- WRITEBACK: `pmem_write` = 1; `pmem_address` = {`tag_in`, index, 5'b0}. On `pmem_resp`, go to FILL.
- FILL: `pmem_read` = 1; `pmem_address` = {address tag, index, 5'b0}.
- FILL, on `pmem_resp`: `data_load` = 1, `data_src` = 0, `tag_load` = 1, `valid_load` = 1, `dirty_load` = 1, `dirty_datain` = 0. Return to CHECK.
- After a fill, the next CHECK cycle sees the written arrays and hits. A write miss therefore completes as a write hit in that cycle.
- `mem_read` and `mem_write` both high: treated as a write.
- A request dropped mid-transaction is illegal; the controller still completes the pmem transaction.

## Timing
- Reset (`rst` low, asynchronous): state = CHECK, counters = 0. All outputs are combinational from state and inputs, so with no request they are all 0.
- Hit latency: `mem_resp` in the same cycle the request is presented.
- Clean miss: `mem_resp` 1 cycle after the `pmem_resp` of the fill.
- Dirty miss: writeback, then fill, then `mem_resp` 1 cycle after the fill's `pmem_resp`.
- Array writes take effect at the edge ending the strobe cycle. The arrays do not bypass, so no read in the same cycle observes a write.
- `pmem_read` and `pmem_write` stay high continuously until `pmem_resp`, and are never high together.
- Reset asserted mid-WRITEBACK or mid-FILL: `pmem_*` drop immediately, with no array load. The cache array reset clears valid.

## Configuration
- `NEW_CACHE_PERF_EN` defined: `hit_count` increments once per request found a hit in CHECK on first presentation. `miss_count` increments once per transition CHECK→WRITEBACK or CHECK→FILL.
- The post-fill hit is not counted as a hit. Both counters are 32-bit and wrap.
- `NEW_CACHE_PERF_EN` undefined: the count ports and counter logic are absent; all other behaviour is identical.

## Structure
- Shared package `new_cache_types`:
  - state enum (CHECK, WRITEBACK, FILL);
  - `OFFSET_W` = 5;
  - `ADDR_W` = 32.
- Sub-module `new_cache_perf`: the two counters plus a "first presentation" flag, instantiated only under the macro.

## Test plan
- Reset, then a read at 0x0000_0040 with all arrays invalid:
  - `pmem_read` rises with `pmem_address` 0x0000_0040;
  - fill loads fire on `pmem_resp`;
  - `mem_resp` pulses 1 cycle later.
- Repeat read at 0x0000_0044: `mem_resp` in the same cycle, no pmem activity, `hit_count` = 1.
- Write hit at 0x0000_0048: `data_load`, `data_src` = 1, `dirty_load`, `dirty_datain` = 1 and `mem_resp` all high in one cycle.
- Read 0x0001_0040 (same index, new tag, dirty victim):
  - `pmem_write` to 0x0000_0040 until `pmem_resp`;
  - then `pmem_read` to 0x0001_0040;
  - fill loads with `dirty_datain` = 0;
  - `mem_resp` follows; `miss_count` = 2.
- Assert `rst` low during FILL: `pmem_read` falls in the same cycle with no array strobes, and the state is CHECK on release.
- `mem_read` and `mem_write` both high on a hit: write strobes assert.
